vdb_vga_timing_gen: RTL and testbench

VGA timing generator and pixel pipeline that drives the virtual-devboard VGA monitor. It counts horizontal and vertical positions per VESA-style parameters and issues one pixel request per active pixel to an upstream pixel source. It returns registered r/g/b with active-low hsync/vsync, all aligned at the monitor inputs. Start and stop happen only on frame boundaries, so the monitor never sees a partial frame.

---
 rtl/vdb_vga_pkg.sv | 40 ++++
 rtl/vdb_vga_timing_gen_if.sv | 30 +++
 rtl/vdb_vga_sync_counter.sv | 53 +++++
 rtl/vdb_vga_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vdb_vga_timing_gen.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/vdb_vga_pkg.sv
// Shared VGA types and helpers for the timing generator and the monitor model.
// The package holds only types, widths and constant functions; it has no latency or backpressure.
package vdb_vga_pkg;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // One axis of VESA timing. Fields are sized for the wider horizontal axis.
    typedef struct packed {
        logic [HCNT_W-1:0] active;
        logic [HCNT_W-1:0] front_porch;
        logic [HCNT_W-1:0] sync;
        logic [HCNT_W-1:0] back_porch;
    } sync_t;

    function automatic sync_t mk_sync(input int act, input int fp, input int sw, input int bp);
        sync_t s;
        s.active      = HCNT_W'(act);
        s.front_porch = HCNT_W'(fp);
        s.sync        = HCNT_W'(sw);
        s.back_porch  = HCNT_W'(bp);
        return s;
    endfunction

    function automatic int sync_total(input sync_t s);
        return int'(s.active) + int'(s.front_porch) + int'(s.sync) + int'(s.back_porch);
    endfunction

endpackage

// File: rtl/vdb_vga_timing_gen_if.sv
// Pixel-request, pixel-return and monitor-facing signals of the VGA timing generator.
// Pure wiring: no latency; the source has no backpressure and must answer one cycle after req.
interface vdb_vga_timing_gen_if;
    import vdb_vga_pkg::*;

    logic              en;
    logic              req;
    logic [HCNT_W-1:0] req_x;
    logic [VCNT_W-1:0] req_y;
    logic              sof;
    logic              pix_valid;
    logic [23:0]       pix_data;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              hsync;
    logic              vsync;
    logic              underflow;

    modport master (
        input  en, pix_valid, pix_data,
        output req, req_x, req_y, sof, r, g, b, hsync, vsync, underflow
    );

    modport slave (
        output en, pix_valid, pix_data,
        input  req, req_x, req_y, sof, r, g, b, hsync, vsync, underflow
    );

endinterface

// File: rtl/vdb_vga_sync_counter.sv
// One timing axis: wrapping position counter plus active and active-low sync decodes.
// Decodes are combinational from the count register; cnt_en stalls the count, clr forces it to 0.
module vdb_vga_sync_counter
    import vdb_vga_pkg::*;
#(
    parameter int    W      = HCNT_W,
    parameter sync_t TIMING = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cnt_en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync_n
);

    localparam int TOTAL      = sync_total(TIMING);
    localparam int SYNC_START = int'(TIMING.active) + int'(TIMING.front_porch);
    localparam int SYNC_END   = SYNC_START + int'(TIMING.sync);

    localparam logic [W-1:0] LAST_L  = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_L   = W'(TIMING.active);
    localparam logic [W-1:0] SSTRT_L = W'(SYNC_START);
    localparam logic [W-1:0] SEND_L  = W'(SYNC_END);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (cnt_en) begin
            count_d = (count_q == LAST_L) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign wrap   = cnt_en && (count_q == LAST_L);
    assign active = (count_q < ACT_L);
    assign sync_n = !((count_q >= SSTRT_L) && (count_q < SEND_L));

endmodule

// File: rtl/vdb_vga_timing_gen.sv
// VGA timing generator: issues one pixel request per active pixel, returns rgb/syncs 2 cycles later.
// No backpressure: a source that misses its slot yields a black pixel and sets sticky underflow.
module vdb_vga_timing_gen
    import vdb_vga_pkg::*;
#(
    parameter int HOR_ACT   = 640,
    parameter int HOR_FP    = 16,
    parameter int HOR_SYNC  = 96,
    parameter int HOR_BP    = 48,
    parameter int VERT_ACT  = 480,
    parameter int VERT_FP   = 11,
    parameter int VERT_SYNC = 2,
    parameter int VERT_BP   = 31
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    vdb_vga_timing_gen_if.master  bus
);

    localparam sync_t H_TIMING = mk_sync(HOR_ACT, HOR_FP, HOR_SYNC, HOR_BP);
    localparam sync_t V_TIMING = mk_sync(VERT_ACT, VERT_FP, VERT_SYNC, VERT_BP);
    localparam int    HTOT     = sync_total(H_TIMING);
    localparam int    VTOT     = sync_total(V_TIMING);

    if (HTOT > 2047 || VTOT > 1023 || HOR_ACT < 1 || HOR_ACT > 1024 ||
        VERT_ACT < 1 || VERT_ACT > 768 || HOR_FP < 0 || HOR_SYNC < 0 || HOR_BP < 0 ||
        VERT_FP < 0 || VERT_SYNC < 0 || VERT_BP < 0) begin : g_bad_cfg
        $fatal(1, "vdb_vga_timing_gen: timing parameters out of range");
    end

    state_t            state_q;
    state_t            state_d;
    logic              run;
    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              h_wrap;
    logic              v_wrap;
    logic              h_act;
    logic              v_act;
    logic              hs_n;
    logic              vs_n;

    assign run = (state_q == ST_RUN);

    vdb_vga_sync_counter #(
        .W      (HCNT_W),
        .TIMING (H_TIMING)
    ) u_hcnt (
        .clk    (pixel_clk),
        .rst    (rst),
        .cnt_en (run),
        .clr    (!run),
        .count  (hcnt),
        .wrap   (h_wrap),
        .active (h_act),
        .sync_n (hs_n)
    );

    vdb_vga_sync_counter #(
        .W      (VCNT_W),
        .TIMING (V_TIMING)
    ) u_vcnt (
        .clk    (pixel_clk),
        .rst    (rst),
        .cnt_en (h_wrap),
        .clr    (!run),
        .count  (vcnt),
        .wrap   (v_wrap),
        .active (v_act),
        .sync_n (vs_n)
    );

    // v_wrap only fires on the last cycle of the last line, so it marks the frame end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.en)            state_d = ST_RUN;
            ST_RUN:  if (v_wrap && !bus.en) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    logic req_c;
    assign req_c     = run && h_act && v_act;
    assign bus.req   = req_c;
    assign bus.req_x = hcnt;
    assign bus.req_y = vcnt;
    assign bus.sof   = run && (hcnt == '0) && (vcnt == '0);

    logic act1_q, act1_d;
    logic hs1_q, hs1_d;
    logic vs1_q, vs1_d;
    rgb_t rgb_q, rgb_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic underflow_q, underflow_d;

    // Syncs are forced inactive outside RUN so the pipeline drains to idle levels.
    always_comb begin
        act1_d      = req_c;
        hs1_d       = hs_n || !run;
        vs1_d       = vs_n || !run;
        rgb_d       = '0;
        hsync_d     = hs1_q;
        vsync_d     = vs1_q;
        underflow_d = underflow_q;
        if (act1_q) begin
            if (bus.pix_valid) begin
                rgb_d = rgb_t'(bus.pix_data);
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            act1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            rgb_q       <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            act1_q      <= act1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.r         = rgb_q.r;
    assign bus.g         = rgb_q.g;
    assign bus.b         = rgb_q.b;
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_vdb_vga_timing_gen.sv
// Directed bench for vdb_vga_timing_gen with small timing (HTOT=15, VTOT=8, 120 cycles/frame).
// A bench-side pixel source answers every request one cycle later with {y,x,8'hA5}.
module tb_vdb_vga_timing_gen;

    localparam int HT = 15;
    localparam int VT = 8;
    localparam int FR = HT * VT;
    localparam int NO_STOP = 1 << 20;

    logic pixel_clk;
    logic rst;

    vdb_vga_timing_gen_if vif ();

    vdb_vga_timing_gen #(
        .HOR_ACT   (8),
        .HOR_FP    (2),
        .HOR_SYNC  (3),
        .HOR_BP    (2),
        .VERT_ACT  (4),
        .VERT_FP   (1),
        .VERT_SYNC (2),
        .VERT_BP   (1)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .bus       (vif)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        last_req = 1'b0;
    logic [10:0] last_x   = '0;
    logic [9:0]  last_y   = '0;
    logic        drop_now = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then act as the pixel source for the request seen last cycle.
    // Outside a request the source drives valid junk, which the DUT must ignore.
    task automatic tick();
        @(posedge pixel_clk);
        #1;
        if (last_req) begin
            vif.pix_valid = !drop_now;
            vif.pix_data  = {8'(last_y), 8'(last_x), 8'hA5};
        end else begin
            vif.pix_valid = 1'b1;
            vif.pix_data  = 24'hC35A3C;
        end
        drop_now = 1'b0;
        last_req = vif.req;
        last_x   = vif.req_x;
        last_y   = vif.req_y;
    endtask

    task automatic check_reset(input string tag);
        chk(tag, 64'({vif.req, vif.sof, vif.req_x, vif.req_y, vif.r, vif.g, vif.b,
                      vif.hsync, vif.vsync, vif.underflow}),
                 64'({1'b0, 1'b0, 11'd0, 10'd0, 24'd0, 1'b1, 1'b1, 1'b0}));
    endtask

    // g counts cycles since the first RUN cycle; cycles after stop_g (or before 0) are idle.
    // drop_g is the request whose pixel the source withheld.
    task automatic check_cycle(input int g, input int stop_g, input int drop_g, input bit exp_uf);
        bit          run_c, prun, ereq, preq, ehs, evs;
        int          h, v, p, ph, pv;
        logic [23:0] ergb;
        run_c = (g >= 0) && (g <= stop_g);
        h     = run_c ? g % HT : 0;
        v     = run_c ? (g / HT) % VT : 0;
        ereq  = run_c && (h < 8) && (v < 4);
        chk("req", 64'(vif.req), 64'(ereq));
        chk("sof", 64'(vif.sof), 64'(run_c && (g % FR == 0)));
        if (ereq) begin
            chk("req_x", 64'(vif.req_x), 64'(h));
            chk("req_y", 64'(vif.req_y), 64'(v));
        end
        p    = g - 2;
        prun = (p >= 0) && (p <= stop_g);
        ph   = prun ? p % HT : 0;
        pv   = prun ? (p / HT) % VT : 0;
        preq = prun && (ph < 8) && (pv < 4);
        ehs  = !(prun && (ph >= 10) && (ph < 13));
        evs  = !(prun && (pv >= 5) && (pv < 7));
        ergb = (preq && (p != drop_g)) ? {8'(pv), 8'(ph), 8'hA5} : 24'h0;
        chk("rgb", 64'({vif.r, vif.g, vif.b}), 64'(ergb));
        chk("hsync", 64'(vif.hsync), 64'(ehs));
        chk("vsync", 64'(vif.vsync), 64'(evs));
        chk("underflow", 64'(vif.underflow), 64'(exp_uf));
    endtask

    initial begin
        int n_req_f1;
        int n_hs_low;
        int n_vs_low;
        int n_sof;
        n_req_f1 = 0;
        n_hs_low = 0;
        n_vs_low = 0;
        n_sof    = 0;

        rst           = 1'b1;
        vif.en        = 1'b0;
        vif.pix_valid = 1'b0;
        vif.pix_data  = '0;
        #1;
        check_reset("reset_t0");
        repeat (3) tick();
        check_reset("reset_held");
        rst = 1'b0;

        // Held idle with en low.
        for (int i = 0; i < 50; i++) begin
            tick();
            check_cycle(-1000, NO_STOP, -1, 1'b0);
        end

        // Three frames; pixel (3,1) of frame 2 is withheld; en drops at (4,2) of frame 3.
        vif.en = 1'b1;
        for (int g = 0; g < 3 * FR + 20; g++) begin
            tick();
            check_cycle(g, 3 * FR - 1, FR + 15 + 3, g >= FR + 15 + 5);
            if (g < FR && vif.req) n_req_f1++;
            if (g >= 2 && g < FR + 2) begin
                if (!vif.hsync) n_hs_low++;
                if (!vif.vsync) n_vs_low++;
            end
            if (vif.sof) n_sof++;
            if (g == FR + 15 + 3) drop_now = 1'b1;
            if (g == 2 * FR + 2 * HT + 4) vif.en = 1'b0;
        end
        chk("reqs_per_frame", 64'(n_req_f1), 64'd32);
        chk("hsync_low_cycles", 64'(n_hs_low), 64'd24);
        chk("vsync_low_cycles", 64'(n_vs_low), 64'd30);
        chk("sof_count", 64'(n_sof), 64'd3);

        // Restart, then reset mid-frame at (5,1).
        vif.en = 1'b1;
        for (int g = 0; g <= HT + 5; g++) begin
            tick();
            check_cycle(g, NO_STOP, -1, 1'b1);
        end
        rst = 1'b1;
        #1;
        check_reset("reset_midframe");
        repeat (2) tick();
        check_reset("reset_midframe_held");
        rst = 1'b0;
        for (int g = 0; g < FR + 10; g++) begin
            tick();
            check_cycle(g, NO_STOP, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
